// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: control codes, opcodes,
// ALUOp encodings, FSM state encoding, decode payload and the decoder.
package alu_pkg;

  localparam int unsigned CTL_W   = 4;
  localparam int unsigned OPC_W   = 11;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned STATE_W = 2;

  // ALU control codes (legacy LEGv8 encoding extended with MUL/UDIV)
  localparam logic [CTL_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [CTL_W-1:0] ALU_ORR    = 4'b0001;
  localparam logic [CTL_W-1:0] ALU_ADD    = 4'b0010;
  localparam logic [CTL_W-1:0] ALU_SUB    = 4'b0110;
  localparam logic [CTL_W-1:0] ALU_PASS_B = 4'b0111;
  localparam logic [CTL_W-1:0] ALU_MUL    = 4'b1000;
  localparam logic [CTL_W-1:0] ALU_UDIV   = 4'b1001;

  // R-type opcodes, instruction[31:21]
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_MUL  = 11'b10011011000;
  localparam logic [OPC_W-1:0] OPC_UDIV = 11'b10011010110;

  // Main-decoder ALUOp encodings
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_MUL  = 2'b01;
  localparam logic [STATE_W-1:0] ST_DIV  = 2'b10;
  localparam logic [STATE_W-1:0] ST_DONE = 2'b11;

  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    logic             illegal;
  } dec_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Decode {alu_op, opcode} into a control code; UDIV falls back to ADD
  // and is flagged illegal when the divider is not built.
  function automatic dec_t alu_decode(input logic [ALUOP_W-1:0] alu_op,
                                      input logic [OPC_W-1:0]   opcode,
                                      input logic               en_div);
    dec_t d;
    d.ctl     = ALU_ADD;
    d.illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD:  d.ctl = ALU_ADD;
      ALUOP_PASS: d.ctl = ALU_PASS_B;
      ALUOP_RSVD: d.illegal = 1'b1;
      default: begin
        case (opcode)
          OPC_SUB: d.ctl = ALU_SUB;
          OPC_AND: d.ctl = ALU_AND;
          OPC_ORR: d.ctl = ALU_ORR;
          OPC_MUL: d.ctl = ALU_MUL;
          OPC_UDIV: begin
            if (en_div) d.ctl = ALU_UDIV;
            else        d.illegal = 1'b1;
          end
          default: d.ctl = ALU_ADD;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative MUL / UDIV engine sharing one shift datapath and counter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       load operands and begin DATA_W iterations
//   is_div      1: restoring divide a/b, 0: shift-add multiply a*b
//   a, b        operands (sampled on start)
//   done        high during the final iteration cycle
//   res         value produced by the final iteration (valid with done)
module alu_iter_muldiv #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] res
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned REM_W = DATA_W + 1;

  // p: product accumulator / partial remainder
  // x: multiplier shifting right / dividend shifting into quotient
  // y: multiplicand shifting left / constant divisor
  logic [DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;

  logic [REM_W-1:0]  rem_sh;
  logic              rem_ge;

  // One iteration per cycle while the counter is non-zero
  always_comb begin
    p_d    = p_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    rem_sh = {p_q, x_q[DATA_W-1]};
    rem_ge = (rem_sh >= {1'b0, y_q});
    if (start) begin
      p_d   = '0;
      x_d   = is_div ? a : b;
      y_d   = is_div ? b : a;
      cnt_d = CNT_W'(DATA_W);
      div_d = is_div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        // remainder after a successful subtract is below the divisor,
        // so it always fits back into DATA_W bits
        p_d = rem_ge ? DATA_W'(rem_sh - {1'b0, y_q}) : rem_sh[DATA_W-1:0];
        x_d = {x_q[DATA_W-2:0], rem_ge};
      end else begin
        if (x_q[0]) p_d = p_q + y_q;
        x_d = x_q >> 1;
        y_d = y_q << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // Forward the last iteration's result so the caller can register it
  // on the same edge the engine finishes.
  assign done = (cnt_q == CNT_W'(1));
  assign res  = div_q ? x_d : p_d;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes {alu_op, opcode}, executes single-cycle ops and
// iterative MUL/UDIV, and returns a registered result with NZCV flags.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    request handshake
//   alu_op, opcode       main-decoder ALUOp and instruction[31:21]
//   op_a, op_b           operands
//   out_valid/out_ready  result handshake
//   result, flags        registered result and {N,Z,C,V}
//   alu_ctl              control code of the held result
//   div_zero, illegal    status of the held result
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   result,
  output logic [FLAGS_W-1:0]  flags,
  output logic [CTL_W-1:0]    alu_ctl,
  output logic                div_zero,
  output logic                illegal
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  flags_t             flags_q, flags_d;
  logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic               div_zero_q, div_zero_d;
  logic               illegal_q, illegal_d;

  dec_t               dec;
  logic               accept;
  logic               b_zero;
  logic               is_sub;
  logic [DATA_W-1:0]  b_eff;
  logic [SUM_W-1:0]   sum;
  logic [DATA_W-1:0]  sc_res;
  flags_t             sc_flags;
  logic               md_start;
  logic               md_is_div;
  logic               md_done;
  logic [DATA_W-1:0]  md_res;

  assign dec      = alu_decode(alu_op, opcode, ENABLE_DIV);
  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign b_zero   = (op_b == '0);

  // Single-cycle datapath; SUB is A + ~B + 1 so C is NOT borrow
  always_comb begin
    is_sub = (dec.ctl == ALU_SUB);
    b_eff  = is_sub ? ~op_b : op_b;
    sum    = {1'b0, op_a} + {1'b0, b_eff} + SUM_W'(is_sub);
    case (dec.ctl)
      ALU_AND:    sc_res = op_a & op_b;
      ALU_ORR:    sc_res = op_a | op_b;
      ALU_PASS_B: sc_res = op_b;
      default:    sc_res = sum[DATA_W-1:0];
    endcase
    sc_flags.n = sc_res[MSB];
    sc_flags.z = (sc_res == '0);
    sc_flags.c = 1'b0;
    sc_flags.v = 1'b0;
    if ((dec.ctl == ALU_ADD) || is_sub) begin
      sc_flags.c = sum[DATA_W];
      sc_flags.v = (op_a[MSB] == b_eff[MSB]) & (sum[MSB] != op_a[MSB]);
    end
  end

  assign md_is_div = (dec.ctl == ALU_UDIV);
  assign md_start  = accept & ((dec.ctl == ALU_MUL) | (md_is_div & ~b_zero));

  alu_iter_muldiv #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (md_is_div),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .res    (md_res)
  );

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    alu_ctl_d   = alu_ctl_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          alu_ctl_d  = dec.ctl;
          illegal_d  = dec.illegal;
          div_zero_d = 1'b0;
          if (dec.ctl == ALU_MUL) begin
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else if (md_is_div && !b_zero) begin
            state_d     = ST_DIV;
            out_valid_d = 1'b0;
          end else if (md_is_div) begin
            // divide by zero short-circuits with a zero quotient
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = '0;
            flags_d     = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
            div_zero_d  = 1'b1;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = sc_res;
            flags_d     = sc_flags;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_MUL, ST_DIV: begin
        if (md_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = md_res;
          flags_d     = '{n: md_res[MSB], z: (md_res == '0), c: 1'b0, v: 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      alu_ctl_q   <= ALU_ADD;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      alu_ctl_q   <= alu_ctl_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign alu_ctl   = alu_ctl_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;

endmodule
